mtimer_ctrl: RTL and testbench

//   Memory-mapped machine timer (mtime/mtimecmp) for the Pipeline data bus.

---
 rtl/mtimer_ctrl.sv | 119 +++++++++++
 tb/tb_mtimer_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer_ctrl.sv
// Memory-mapped machine timer (mtime/mtimecmp) with a registered level interrupt; reads return one cycle later, never stall.
// Defining MTIMER_PRESCALER_EN adds a 16-bit PRESCALE register at 0x4008 that slows the mtime tick.
module mtimer_ctrl #(
  parameter logic [31:0] BASE           = 32'h4400_0000,
  parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        mem_hit,
  output logic        irq_timer,
  output logic [63:0] mtime_o
);

  localparam logic [13:0] OFF_CMP_LO = 14'h1000;
  localparam logic [13:0] OFF_CMP_HI = 14'h1001;
  localparam logic [13:0] OFF_PRE    = 14'h1002;
  localparam logic [13:0] OFF_MT_LO  = 14'h2ffe;
  localparam logic [13:0] OFF_MT_HI  = 14'h2fff;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        in_win;
  logic        wr;
  logic        rd;
  logic [13:0] off;
  logic        tick;
  logic        wr_mt;
  logic [31:0] rd_val;
  logic        unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  assign in_win  = (mem_addr[31:16] == BASE[31:16]);
  assign off     = mem_addr[15:2];
  assign wr      = mem_valid & mem_write & in_win;
  assign rd      = mem_valid & ~mem_write & in_win;
  // Any write to an mtime word, even with an empty mask, freezes the counter for that cycle.
  assign wr_mt   = wr & ((off == OFF_MT_LO) | (off == OFF_MT_HI));
  assign mtime_o = mtime;

`ifdef MTIMER_PRESCALER_EN
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic        wr_pre;

  assign wr_pre      = wr & (off == OFF_PRE);
  assign tick        = (pcnt == prescale);
  assign unused_bits = ^mem_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= PRESCALE_RESET;
      pcnt     <= 16'd0;
    end else if (wr_pre) begin
      if (mem_wmask[0]) prescale[7:0]  <= mem_wdata[7:0];
      if (mem_wmask[1]) prescale[15:8] <= mem_wdata[15:8];
      pcnt <= 16'd0;
    end else if (tick) begin
      pcnt <= 16'd0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end
`else
  assign tick        = 1'b1;
  assign unused_bits = ^{PRESCALE_RESET, mem_addr[1:0]};
`endif

  always_comb begin
    rd_val = 32'd0;
    case (off)
      OFF_CMP_LO: rd_val = mtimecmp[31:0];
      OFF_CMP_HI: rd_val = mtimecmp[63:32];
      OFF_MT_LO:  rd_val = mtime[31:0];
      OFF_MT_HI:  rd_val = mtime[63:32];
`ifdef MTIMER_PRESCALER_EN
      OFF_PRE:    rd_val = {16'd0, prescale};
`endif
      default:    rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= 64'd0;
      mtimecmp  <= '1;
      irq_timer <= 1'b0;
      mem_rdata <= 32'd0;
      mem_hit   <= 1'b0;
    end else begin
      mem_hit   <= mem_valid & in_win;
      mem_rdata <= rd ? rd_val : 32'd0;
      irq_timer <= (mtime >= mtimecmp);
      if (wr && off == OFF_CMP_LO) mtimecmp[31:0]  <= merge(mtimecmp[31:0],  mem_wdata, mem_wmask);
      if (wr && off == OFF_CMP_HI) mtimecmp[63:32] <= merge(mtimecmp[63:32], mem_wdata, mem_wmask);
      if (wr_mt) begin
        if (off == OFF_MT_LO) mtime[31:0]  <= merge(mtime[31:0],  mem_wdata, mem_wmask);
        else                  mtime[63:32] <= merge(mtime[63:32], mem_wdata, mem_wmask);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_mtimer_ctrl.sv
// Bench for mtimer_ctrl: constant vector table, hand sequences for multi-cycle corners, random traffic vs a reference model.
module tb_mtimer_ctrl;

  localparam logic [31:0] A_CLO = 32'h4400_4000;
  localparam logic [31:0] A_CHI = 32'h4400_4004;
  localparam logic [31:0] A_PRE = 32'h4400_4008;
  localparam logic [31:0] A_MLO = 32'h4400_bff8;
  localparam logic [31:0] A_MHI = 32'h4400_bffc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_wmask = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_addr  = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_hit;
  logic        irq_timer;
  logic [63:0] mtime_o;

  int nvec = 0;
  int nerr = 0;

  mtimer_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_hit(mem_hit), .irq_timer(irq_timer), .mtime_o(mtime_o)
  );

  always #5 clk = ~clk;

  // Reference model: timer state as plain 64-bit integers.
  longint unsigned m_mtime, m_cmp;
  bit              m_irq, m_hit;
  bit [31:0]       m_rdata;
  bit [15:0]       m_pre, m_pcnt;

  function automatic bit [31:0] mrg(input bit [31:0] old, input bit [31:0] d, input bit [3:0] m);
    bit [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit [31:0] mread(input bit [15:0] o);
    case (o)
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hbff8: return m_mtime[31:0];
      16'hbffc: return m_mtime[63:32];
`ifdef MTIMER_PRESCALER_EN
      16'h4008: return {16'h0, m_pre};
`endif
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = 0; m_cmp = '1; m_irq = 0; m_hit = 0; m_rdata = 0; m_pre = 16'd0; m_pcnt = 16'd0;
  endtask

  task automatic model_edge(input bit v, input bit w, input bit [3:0] m, input bit [31:0] d,
                            input bit [31:0] a);
    bit              win = (a[31:16] == 16'h4400);
    bit [15:0]       o = {a[15:2], 2'b00};
    bit              wr = v && w && win;
    bit              rd = v && !w && win;
    bit              tick;
    longint unsigned nt = m_mtime;
    longint unsigned nc = m_cmp;
    bit              nirq = (m_mtime >= m_cmp);
`ifdef MTIMER_PRESCALER_EN
    tick = (m_pcnt == m_pre);
`else
    tick = 1'b1;
`endif
    m_rdata = rd ? mread(o) : 32'h0;
    m_hit   = v && win;
    if (wr && o == 16'h4000) nc[31:0]  = mrg(m_cmp[31:0], d, m);
    if (wr && o == 16'h4004) nc[63:32] = mrg(m_cmp[63:32], d, m);
    if (wr && (o == 16'hbff8 || o == 16'hbffc)) begin
      if (o == 16'hbff8) nt[31:0]  = mrg(m_mtime[31:0], d, m);
      else               nt[63:32] = mrg(m_mtime[63:32], d, m);
    end else if (tick) begin
      nt = m_mtime + 1;
    end
`ifdef MTIMER_PRESCALER_EN
    if (wr && o == 16'h4008) begin
      if (m[0]) m_pre[7:0]  = d[7:0];
      if (m[1]) m_pre[15:8] = d[15:8];
      m_pcnt = 16'd0;
    end else begin
      m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    end
`endif
    m_mtime = nt;
    m_cmp   = nc;
    m_irq   = nirq;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input bit w, input bit [3:0] m, input bit [31:0] d,
                      input bit [31:0] a);
    mem_valid = v; mem_write = w; mem_wmask = m; mem_wdata = d; mem_addr = a;
    @(posedge clk);
    model_edge(v, w, m, d, a);
    #1;
    check("model_hit",   64'(mem_hit),   64'(m_hit));
    check("model_rdata", 64'(mem_rdata), 64'(m_rdata));
    check("model_irq",   64'(irq_timer), 64'(m_irq));
    check("model_mtime", mtime_o,        m_mtime);
    mem_valid = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wr32(input bit [31:0] a, input bit [31:0] d, input bit [3:0] m);
    step(1'b1, 1'b1, m, d, a);
  endtask

  task automatic rd32(input bit [31:0] a);
    step(1'b1, 1'b0, 4'h0, 32'h0, a);
  endtask

  typedef struct {
    bit        v;
    bit        w;
    bit [3:0]  mask;
    bit [31:0] data;
    bit [31:0] addr;
    bit [31:0] exp_rdata;
    bit        exp_hit;
  } vec_t;

  vec_t tbl[13];
  bit [31:0] raddr[7];
  logic [63:0] t0;

  initial begin
    tbl[0]  = '{1, 0, 4'h0, 32'h0,         A_CHI,         32'hFFFF_FFFF, 1};
    tbl[1]  = '{1, 1, 4'hF, 32'h1122_3344, A_CLO,         32'h0,         1};
    tbl[2]  = '{1, 1, 4'h2, 32'hAABB_CCDD, A_CLO,         32'h0,         1};
    tbl[3]  = '{1, 0, 4'h0, 32'h0,         A_CLO,         32'h1122_CC44, 1};
    tbl[4]  = '{1, 1, 4'h0, 32'h5555_5555, A_CLO,         32'h0,         1};
    tbl[5]  = '{1, 0, 4'h0, 32'h0,         A_CLO,         32'h1122_CC44, 1};
    tbl[6]  = '{1, 0, 4'h0, 32'h0,         32'h7000_0010, 32'h0,         0};
    tbl[7]  = '{1, 0, 4'h0, 32'h0,         A_PRE,         32'h0,         1};
    tbl[8]  = '{1, 1, 4'hF, 32'hDEAD_BEEF, 32'h4400_0000, 32'h0,         1};
    tbl[9]  = '{1, 0, 4'h0, 32'h0,         32'h4400_0000, 32'h0,         1};
    tbl[10] = '{0, 0, 4'h0, 32'h0,         A_CLO,         32'h0,         0};
    tbl[11] = '{1, 1, 4'hF, 32'h0,         32'h4401_4000, 32'h0,         0};
    tbl[12] = '{1, 0, 4'h0, 32'h0,         A_CLO,         32'h1122_CC44, 1};
    raddr = '{A_CLO, A_CHI, A_MLO, A_MHI, A_PRE, 32'h4400_1234, 32'h5000_4000};

    model_reset();
    #3;
    check("rst_mtime", mtime_o, 64'h0);
    check("rst_irq",   64'(irq_timer), 64'h0);
    check("rst_hit",   64'(mem_hit),   64'h0);
    check("rst_rdata", 64'(mem_rdata), 64'h0);
    #9 rst = 1'b0;

    // Free-running count and read-back after reset
    repeat (3) idle();
    check("t1_count", mtime_o, 64'd3);
    rd32(A_CLO);
    check("t1_cmp_lo", 64'(mem_rdata), 64'hFFFF_FFFF);
    check("t1_hit", 64'(mem_hit), 64'h1);
    rd32(A_MLO);
    check("t1_mtime_rd", 64'(mem_rdata), 64'd4);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].mask, tbl[i].data, tbl[i].addr);
      check($sformatf("vec%0d_rdata", i), 64'(mem_rdata), 64'(tbl[i].exp_rdata));
      check($sformatf("vec%0d_hit", i),   64'(mem_hit),   64'(tbl[i].exp_hit));
    end

    // Interrupt rises one edge after mtime reaches mtimecmp, falls after raising mtimecmp
    wr32(A_MHI, 32'h0, 4'hF);
    wr32(A_MLO, 32'h10, 4'hF);
    check("t2_mtime_wr", mtime_o, 64'h10);
    wr32(A_CHI, 32'h0, 4'hF);
    wr32(A_CLO, 32'h40, 4'hF);
    for (int i = 0; i < 100 && mtime_o != 64'h40; i++) idle();
    check("t2_reach", mtime_o, 64'h40);
    check("t2_irq_pre", 64'(irq_timer), 64'h0);
    idle();
    check("t2_irq_rise", 64'(irq_timer), 64'h1);
    wr32(A_CHI, 32'hFFFF_FFFF, 4'hF);
    idle();
    check("t2_irq_fall", 64'(irq_timer), 64'h0);

    // Carry from low word into high word; write cycle holds the written value
    wr32(A_MHI, 32'h0, 4'hF);
    wr32(A_MLO, 32'hFFFF_FFFE, 4'hF);
    check("t4_wr_hold", mtime_o, 64'h0000_0000_FFFF_FFFE);
    idle();
    check("t4_ffff", mtime_o, 64'h0000_0000_FFFF_FFFF);
    idle();
    check("t4_carry", mtime_o, 64'h0000_0001_0000_0000);

    // 64-bit wrap
    wr32(A_MHI, 32'hFFFF_FFFF, 4'hF);
    wr32(A_MLO, 32'hFFFF_FFFF, 4'hF);
    check("t5_ones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    check("t5_wrap", mtime_o, 64'h0);
    check("t5_irq_hi", 64'(irq_timer), 64'h1);
    idle();
    check("t5_after", mtime_o, 64'h1);
    check("t5_irq_lo", 64'(irq_timer), 64'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, raddr[$urandom_range(0, 6)]);
    end

    // Reset in the middle of a write cycle: nothing lands
    mem_valid = 1'b1; mem_write = 1'b1; mem_wmask = 4'hF; mem_wdata = 32'h0; mem_addr = A_CLO;
    #2 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    mem_valid = 1'b0; mem_write = 1'b0;
    model_reset();
    #1;
    check("t6_rst_mtime", mtime_o, 64'h0);
    check("t6_rst_hit", 64'(mem_hit), 64'h0);
    rd32(A_CLO);
    check("t6_cmp_kept", 64'(mem_rdata), 64'hFFFF_FFFF);
    rd32(32'h7000_0010);
    check("t6_out_hit", 64'(mem_hit), 64'h0);
    check("t6_out_rdata", 64'(mem_rdata), 64'h0);

`ifdef MTIMER_PRESCALER_EN
    wr32(A_PRE, 32'h0000_0003, 4'h3);
    t0 = mtime_o;
    repeat (8) idle();
    check("t6_prescale", mtime_o, t0 + 64'd2);
    rd32(A_PRE);
    check("t6_pre_rd", 64'(mem_rdata), 64'h3);
    repeat (10) idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
